// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter: round-robin arbiter that lets one read port and one write port share a
// single-word SDRAM controller interface. Only one read is ever in flight, and every output is
// registered.
//
// Ports:
//   clk, n_rst                 clock (rising edge) and asynchronous active-low reset
//   rd_req, rd_addr            read request and address (held while rd_req=1)
//   rd_gnt, rd_valid, rd_err   one-cycle pulses: read accepted, data returned, read timed out
//   rd_data                    returned read word
//   wr_req, wr_addr, wr_data   write request, address and data (held while wr_req=1)
//   wr_gnt                     one-cycle pulse: write issued
//   sdram_read_en/write_en     SDRAM strobes (never high together)
//   address_sdram              SDRAM address
//   writeData_sdram            SDRAM write data
//   data_sdram                 SDRAM read data
//   sdram_datareadvalid        SDRAM read-data qualifier
//   busy                       high whenever the FSM is outside IDLE
module sdram_port_arbiter #(
  parameter int unsigned ADDR_W  = 26,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_gnt,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              rd_err,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_gnt,
  output logic              sdram_read_en,
  output logic              sdram_write_en,
  output logic [ADDR_W-1:0] address_sdram,
  output logic [DATA_W-1:0] writeData_sdram,
  input  logic [DATA_W-1:0] data_sdram,
  input  logic              sdram_datareadvalid,
  output logic              busy
);

  localparam logic [7:0] TimeoutCnt = 8'(TIMEOUT);

  typedef enum logic [1:0] {StIdle, StRdIssue, StRdWait, StWrIssue} state_e;

  state_e              state_q, state_d;
  logic                last_wr_q, last_wr_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [7:0]          cnt_inc;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rd_data_q, rd_data_d;
  logic                rd_gnt_q, rd_gnt_d;
  logic                wr_gnt_q, wr_gnt_d;
  logic                rd_valid_q, rd_valid_d;
  logic                rd_err_q, rd_err_d;
  logic                read_en_q, read_en_d;
  logic                write_en_q, write_en_d;
  logic                busy_q, busy_d;

  assign cnt_inc = cnt_q + 8'd1;

  // Outputs are driven from next-state values so each registered strobe lines up exactly with
  // the cycle the FSM spends in the corresponding state.
  always_comb begin
    state_d    = state_q;
    last_wr_d  = last_wr_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rd_data_d  = rd_data_q;
    rd_gnt_d   = 1'b0;
    wr_gnt_d   = 1'b0;
    rd_valid_d = 1'b0;
    rd_err_d   = 1'b0;
    read_en_d  = 1'b0;
    write_en_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        // On a tie the write wins unless the write was the last one served.
        if (wr_req && (!rd_req || !last_wr_q)) begin
          state_d    = StWrIssue;
          addr_d     = wr_addr;
          wdata_d    = wr_data;
          wr_gnt_d   = 1'b1;
          write_en_d = 1'b1;
        end else if (rd_req) begin
          state_d   = StRdIssue;
          addr_d    = rd_addr;
          rd_gnt_d  = 1'b1;
          read_en_d = 1'b1;
        end
      end
      StRdIssue: begin
        state_d   = StRdWait;
        last_wr_d = 1'b0;
        cnt_d     = 8'd0;
      end
      StRdWait: begin
        cnt_d = cnt_inc;
        // Valid data on the final wait cycle still wins over the timeout.
        if (sdram_datareadvalid) begin
          state_d    = StIdle;
          rd_data_d  = data_sdram;
          rd_valid_d = 1'b1;
        end else if (cnt_inc == TimeoutCnt) begin
          state_d  = StIdle;
          rd_err_d = 1'b1;
        end
      end
      StWrIssue: begin
        state_d   = StIdle;
        last_wr_d = 1'b1;
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= StIdle;
      last_wr_q  <= 1'b0;
      cnt_q      <= 8'd0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rd_data_q  <= '0;
      rd_gnt_q   <= 1'b0;
      wr_gnt_q   <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_err_q   <= 1'b0;
      read_en_q  <= 1'b0;
      write_en_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_wr_q  <= last_wr_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rd_data_q  <= rd_data_d;
      rd_gnt_q   <= rd_gnt_d;
      wr_gnt_q   <= wr_gnt_d;
      rd_valid_q <= rd_valid_d;
      rd_err_q   <= rd_err_d;
      read_en_q  <= read_en_d;
      write_en_q <= write_en_d;
      busy_q     <= busy_d;
    end
  end

  assign rd_gnt          = rd_gnt_q;
  assign wr_gnt          = wr_gnt_q;
  assign rd_data         = rd_data_q;
  assign rd_valid        = rd_valid_q;
  assign rd_err          = rd_err_q;
  assign sdram_read_en   = read_en_q;
  assign sdram_write_en  = write_en_q;
  assign address_sdram   = addr_q;
  assign writeData_sdram = wdata_q;
  assign busy            = busy_q;

endmodule
